// File: rtl/stream_mem_scheduler.sv
// stream_mem_scheduler: alternating read/write arbiter onto a single-port memory, returning
// tagged read responses in order through a credit-protected response FIFO.
module stream_mem_scheduler #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 64,
   parameter int CH_ID_W    = 3,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [CH_ID_W+ADDR_WIDTH-1:0]   s_axis_rd_tdata,
   input  logic                            s_axis_rd_tvalid,
   output logic                            s_axis_rd_tready,
   input  logic                            s_axis_rd_tlast,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_axis_wr_tdata,
   input  logic                            s_axis_wr_tvalid,
   output logic                            s_axis_wr_tready,
   input  logic                            s_axis_wr_tlast,
   output logic [CH_ID_W+DATA_WIDTH-1:0]   m_axis_rsp_tdata,
   output logic                            m_axis_rsp_tvalid,
   input  logic                            m_axis_rsp_tready,
   output logic                            m_axis_rsp_tlast,
   output logic                            mem_en,
   output logic                            mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   input  logic [DATA_WIDTH-1:0]           mem_rdata,
   input  logic                            quiesce,
   output logic                            idle,
   output logic [31:0]                     stat_rd_count,
   output logic [31:0]                     stat_wr_count
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int RW = CH_ID_W + DATA_WIDTH;

   logic [RW-1:0]      fifo_q [RSP_DEPTH];
   logic [PW-1:0]      wptr_q, rptr_q;
   logic [PW:0]        cnt_q, cnt_d;
   logic               rd_inflight_q, prio_q;
   logic [CH_ID_W-1:0] ch_q;
   logic [31:0]        rd_cnt_q, wr_cnt_q;
   logic [PW+1:0]      occ;
   logic               pop, credit_ok, rd_elig, wr_elig, grant_rd, grant_wr;
   logic               unused_tlast;

   assign unused_tlast = s_axis_rd_tlast ^ s_axis_wr_tlast;

   // Credit counts the slot reserved by a read still in the memory pipeline.
   assign pop       = m_axis_rsp_tvalid & m_axis_rsp_tready;
   assign occ       = {1'b0, cnt_q} + {{(PW+1){1'b0}}, rd_inflight_q} - {{(PW+1){1'b0}}, pop};
   assign credit_ok = occ < (PW+2)'(RSP_DEPTH);
   assign rd_elig   = rst_n & s_axis_rd_tvalid & !quiesce & credit_ok;
   assign wr_elig   = rst_n & s_axis_wr_tvalid & !quiesce;
   assign grant_rd  = rd_elig & (!wr_elig | !prio_q);
   assign grant_wr  = wr_elig & (!rd_elig | prio_q);

   assign s_axis_rd_tready = grant_rd;
   assign s_axis_wr_tready = grant_wr;
   assign mem_en    = grant_rd | grant_wr;
   assign mem_we    = grant_wr;
   assign mem_addr  = grant_rd ? s_axis_rd_tdata[ADDR_WIDTH-1:0] :
                      grant_wr ? s_axis_wr_tdata[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH] : '0;
   assign mem_wdata = grant_wr ? s_axis_wr_tdata[DATA_WIDTH-1:0] : '0;

   assign m_axis_rsp_tvalid = cnt_q != '0;
   assign m_axis_rsp_tdata  = m_axis_rsp_tvalid ? fifo_q[rptr_q] : '0;
   assign m_axis_rsp_tlast  = 1'b1;
   assign idle          = !rd_inflight_q & (cnt_q == '0);
   assign stat_rd_count = rd_cnt_q;
   assign stat_wr_count = wr_cnt_q;
   assign cnt_d = cnt_q + {{PW{1'b0}}, rd_inflight_q} - {{PW{1'b0}}, pop};

   always_ff @(posedge clk)
      if (rd_inflight_q) fifo_q[wptr_q] <= {ch_q, mem_rdata};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr_q        <= '0;
         rptr_q        <= '0;
         cnt_q         <= '0;
         rd_inflight_q <= 1'b0;
         ch_q          <= '0;
         prio_q        <= 1'b0;
         rd_cnt_q      <= '0;
         wr_cnt_q      <= '0;
      end else begin
         if (rd_inflight_q) wptr_q <= wptr_q + 1'b1;
         if (pop) rptr_q <= rptr_q + 1'b1;
         cnt_q         <= cnt_d;
         rd_inflight_q <= grant_rd;
         if (grant_rd) ch_q <= s_axis_rd_tdata[CH_ID_W+ADDR_WIDTH-1 -: CH_ID_W];
         if (grant_rd | grant_wr) prio_q <= grant_rd;
         if (grant_rd) rd_cnt_q <= rd_cnt_q + 1'b1;
         if (grant_wr) wr_cnt_q <= wr_cnt_q + 1'b1;
      end
endmodule
